// File: rtl/fetch_prefetch_if.sv
// Prefetch buffer bus bundle: redirect input, instruction stream to the
// fetch stage, and the single-outstanding IRAM request channel.
// master = prefetch buffer side, slave = core/IRAM environment side.
interface fetch_prefetch_if;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    input  redirect, redirect_addr, inst_ready, imem_ready, imem_rdata,
    output inst_valid, inst_addr, inst_data, imem_valid, imem_addr
  );

  modport slave (
    output redirect, redirect_addr, inst_ready, imem_ready, imem_rdata,
    input  inst_valid, inst_addr, inst_data, imem_valid, imem_addr
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetch buffer: streams sequential words from the fetch
// pointer into a FIFO of {addr,data} entries, one outstanding IRAM request,
// fetch limited to [IRAM_BASE, IRAM_TOP). A redirect flushes everything.
// Optional feature: define PREFETCH_BYPASS_EN for a combinational
// IRAM-to-inst path when the FIFO is empty.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, response will be kept
// DRAIN | request outstanding after a redirect, response will be dropped
module fetch_prefetch #(
  parameter int unsigned PREFETCH_DEPTH = 4,
  parameter logic [31:0] IRAM_BASE      = 32'h0,
  parameter logic [31:0] IRAM_TOP       = 32'h20000
) (
  input logic              clock,
  input logic              reset,
  fetch_prefetch_if.master bus
);
  localparam int unsigned      ENTRIES = 1 << PREFETCH_DEPTH;
  localparam int unsigned      CNT_W   = PREFETCH_DEPTH + 1;
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(ENTRIES);
  localparam logic [31:0]      SPAN    = IRAM_TOP - IRAM_BASE;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                state;
  logic [31:0]               fetch_ptr;
  logic [31:0]               req_addr;
  logic [31:0]               ptr_inc;
  logic [31:0]               redirect_word;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_next;
  logic [PREFETCH_DEPTH-1:0] rd_ptr;
  logic [PREFETCH_DEPTH-1:0] wr_ptr;
  logic [31:0]               addr_mem [ENTRIES];
  logic [31:0]               data_mem [ENTRIES];
  logic                      resp_take;
  logic                      bypass_hit;
  logic                      push;
  logic                      fifo_pop;

  // One unsigned compare covers both bounds: addresses below the base wrap high.
  function automatic logic in_range(input logic [31:0] p);
    return (p - IRAM_BASE) < SPAN;
  endfunction

  // Handshake decode and FIFO occupancy for the next cycle.
  always_comb begin
    ptr_inc       = fetch_ptr + 32'd4;
    redirect_word = {bus.redirect_addr[31:2], 2'b00};
    resp_take     = (state == WAIT) && bus.imem_ready && !bus.redirect;
`ifdef PREFETCH_BYPASS_EN
    bypass_hit    = resp_take && (count == '0);
`else
    bypass_hit    = 1'b0;
`endif
    push          = resp_take && !(bypass_hit && bus.inst_ready);
    fifo_pop      = (count != '0) && bus.inst_ready;
    count_next    = count + CNT_W'(push) - CNT_W'(fifo_pop);
  end

  // Instruction head: FIFO head, or the live response when bypassing an empty FIFO.
  always_comb begin
    bus.inst_valid = 1'b0;
    bus.inst_addr  = '0;
    bus.inst_data  = '0;
    if (count != '0) begin
      bus.inst_valid = 1'b1;
      bus.inst_addr  = addr_mem[rd_ptr];
      bus.inst_data  = data_mem[rd_ptr];
    end else if (bypass_hit) begin
      bus.inst_valid = 1'b1;
      bus.inst_addr  = req_addr;
      bus.inst_data  = bus.imem_rdata;
    end
  end

  // Request outputs come straight from registers.
  always_comb begin
    bus.imem_valid = (state != IDLE);
    bus.imem_addr  = req_addr;
  end

  // Request sequencing and fetch pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_ptr <= IRAM_BASE;
      req_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_ptr <= redirect_word;
          end else if ((count < CAP) && in_range(fetch_ptr)) begin
            req_addr <= fetch_ptr;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            fetch_ptr <= redirect_word;
            state     <= bus.imem_ready ? IDLE : DRAIN;
          end else if (bus.imem_ready) begin
            fetch_ptr <= ptr_inc;
            if ((count_next < CAP) && in_range(ptr_inc)) begin
              req_addr <= ptr_inc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (bus.redirect) begin
            fetch_ptr <= redirect_word;
          end
          if (bus.imem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO occupancy and pointers; a flush wins over same-cycle push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; only entries below count are ever visible, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      data_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: a queue-based transaction model
// predicts the request channel and instruction head every cycle, plus
// directed constant checks for the fill, drain, range and flush corners.
module tb_fetch_prefetch;
  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_prefetch_if bus ();

  fetch_prefetch #(
    .PREFETCH_DEPTH(4),
    .IRAM_BASE     (32'h0),
    .IRAM_TOP      (32'h20000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_ptr;
  logic [31:0] m_req;
  bit          m_busy;
  bit          m_drop;
  logic [97:0] exp_v;

  // IRAM_BASE is zero, so only the top bound can exclude an address.
  function automatic bit in_rng(input logic [31:0] p);
    return p < 32'h20000;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ptr  = 32'h0;
    m_req  = 32'h0;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_update();
    int n;
    bit pop;
    n   = q.size();
    pop = (n > 0) && bus.inst_ready;
    if (bus.redirect) begin
      q.delete();
      m_ptr = {bus.redirect_addr[31:2], 2'b00};
      if (m_busy) begin
        if (bus.imem_ready) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else if (m_busy && m_drop) begin
      if (pop) void'(q.pop_front());
      if (bus.imem_ready) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
    end else if (m_busy) begin
      if (pop) void'(q.pop_front());
      if (bus.imem_ready) begin
        if (!(BYP && n == 0 && bus.inst_ready)) q.push_back('{a: m_req, d: bus.imem_rdata});
        m_ptr = m_ptr + 32'd4;
        if (q.size() < 16 && in_rng(m_ptr)) m_req = m_ptr;
        else m_busy = 1'b0;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (n < 16 && in_rng(m_ptr)) begin
        m_busy = 1'b1;
        m_req  = m_ptr;
      end
    end
  endfunction

  function automatic logic [97:0] model_expect();
    logic        iv;
    logic [31:0] ia;
    logic [31:0] id;
    iv = 1'b0;
    ia = 32'h0;
    id = 32'h0;
    if (q.size() != 0) begin
      iv = 1'b1;
      ia = q[0].a;
      id = q[0].d;
    end else if (BYP && m_busy && !m_drop && bus.imem_ready && !bus.redirect) begin
      iv = 1'b1;
      ia = m_req;
      id = bus.imem_rdata;
    end
    return {m_busy, m_req, iv, ia, id};
  endfunction

  function automatic logic [97:0] obs_vec();
    logic v;
    v = bus.inst_valid;
    return {bus.imem_valid, bus.imem_addr, v, v ? bus.inst_addr : 32'h0, v ? bus.inst_data : 32'h0};
  endfunction

  task automatic drive(input bit red, input logic [31:0] ra, input bit ir, input bit mr);
    bus.redirect      = red;
    bus.redirect_addr = ra;
    bus.inst_ready    = ir;
    bus.imem_ready    = mr;
    bus.imem_rdata    = $urandom;
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_total++;
    if ({bus.imem_valid, bus.imem_addr, bus.inst_valid, bus.inst_addr, bus.inst_data} !== 98'h0)
      $display("FAIL reset_values got %h want 0",
               {bus.imem_valid, bus.imem_addr, bus.inst_valid, bus.inst_addr, bus.inst_data});
    else n_pass++;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      bus.imem_rdata = m_req ^ 32'hA5A5A5A5;
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL stream c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_fill();
    int          nreq;
    logic [31:0] raddr;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL fill c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    n_total++;
    if (bus.imem_valid !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h0)
      $display("FAIL fill_full got iv=%b v=%b head=%h want iv=0 v=1 head=0",
               bus.imem_valid, bus.inst_valid, bus.inst_addr);
    else n_pass++;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    advance();
    nreq  = 0;
    raddr = 32'hFFFFFFFF;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL refill c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      if (bus.imem_valid) begin
        nreq++;
        raddr = bus.imem_addr;
      end
      advance();
    end
    n_total++;
    if (nreq != 1 || raddr !== 32'h40)
      $display("FAIL refill_one got %0d reqs addr %h want 1 reqs addr 00000040", nreq, raddr);
    else n_pass++;
  endtask

  task automatic test_drain();
    bit found;
    bit seen;
    apply_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (m_busy && m_req == 32'h8) begin
        found = 1'b1;
      end else begin
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clock);
        exp_v = model_expect();
        n_total++;
        if (obs_vec() !== exp_v) $display("FAIL drain_pre c%0d got %h want %h", c, obs_vec(), exp_v);
        else n_pass++;
        advance();
      end
    end
    n_total++;
    if (!found || bus.imem_addr !== 32'h8) $display("FAIL drain_reach got %h want 00000008", bus.imem_addr);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 32'h103, 1'b1, 1'b0);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL drain_hold c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      advance();
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL drain_post c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      if (bus.inst_valid && !seen) begin
        seen = 1'b1;
        n_total++;
        if (bus.inst_addr !== 32'h100) $display("FAIL drain_first got %h want 00000100", bus.inst_addr);
        else n_pass++;
      end
      advance();
    end
    n_total++;
    if (!seen) $display("FAIL drain_resume got no inst_valid want inst at 00000100");
    else n_pass++;
  endtask

  task automatic test_top_bound();
    logic [31:0] got[$];
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c == 0, 32'h1FFF8, 1'b1, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL top c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      if (bus.imem_valid) got.push_back(bus.imem_addr);
      advance();
    end
    n_total++;
    if (got.size() != 2) $display("FAIL top_count got %0d want 2", got.size());
    else if (got[0] !== 32'h1FFF8 || got[1] !== 32'h1FFFC)
      $display("FAIL top_addrs got %h %h want 0001fff8 0001fffc", got[0], got[1]);
    else n_pass++;
    n_total++;
    if (bus.imem_valid !== 1'b0) $display("FAIL top_idle got %b want 0", bus.imem_valid);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    bit          any;
    bit          seen;
    logic [31:0] first;
    apply_reset();
    any = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, 32'h20000, 1'b1, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL oor c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      if (bus.imem_valid || bus.inst_valid) any = 1'b1;
      advance();
    end
    n_total++;
    if (any) $display("FAIL oor_quiet got activity want none");
    else n_pass++;
    seen  = 1'b0;
    first = 32'hFFFFFFFF;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL oor_resume c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      if (bus.imem_valid && !seen) begin
        seen  = 1'b1;
        first = bus.imem_addr;
      end
      advance();
    end
    n_total++;
    if (first !== 32'h0) $display("FAIL oor_first got %h want 00000000", first);
    else n_pass++;
  endtask

  task automatic test_flush_collision();
    bit ready_to_hit;
    apply_reset();
    ready_to_hit = 1'b0;
    for (int c = 0; c < 10 && !ready_to_hit; c++) begin
      if (q.size() > 0 && m_busy) begin
        ready_to_hit = 1'b1;
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clock);
        exp_v = model_expect();
        n_total++;
        if (obs_vec() !== exp_v) $display("FAIL coll_pre c%0d got %h want %h", c, obs_vec(), exp_v);
        else n_pass++;
        advance();
      end
    end
    drive(1'b1, 32'h242, 1'b1, 1'b1);
    @(negedge clock);
    n_total++;
    if (!ready_to_hit || bus.inst_valid !== 1'b1 || bus.imem_valid !== 1'b1)
      $display("FAIL coll_setup got v=%b iv=%b want v=1 iv=1", bus.inst_valid, bus.imem_valid);
    else n_pass++;
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    n_total++;
    if (bus.inst_valid !== 1'b0 || bus.imem_valid !== 1'b0)
      $display("FAIL coll_flush got v=%b iv=%b want v=0 iv=0", bus.inst_valid, bus.imem_valid);
    else n_pass++;
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    n_total++;
    if (bus.imem_valid !== 1'b1 || bus.imem_addr !== 32'h240)
      $display("FAIL coll_ptr got iv=%b addr=%h want iv=1 addr=00000240", bus.imem_valid, bus.imem_addr);
    else n_pass++;
    advance();
    // Latency from an empty FIFO: response at cycle T shows at T (bypass) or T+1.
    apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    n_total++;
    if (bus.inst_valid !== BYP) $display("FAIL latency_T got %b want %b", bus.inst_valid, BYP);
    else n_pass++;
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    n_total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 32'h0)
      $display("FAIL latency_T1 got v=%b addr=%h want v=1 addr=0", bus.inst_valid, bus.inst_addr);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.imem_valid, bus.imem_addr, bus.inst_valid, bus.inst_addr, bus.inst_data} !== 98'h0)
      $display("FAIL reset_mid got %h want 0",
               {bus.imem_valid, bus.imem_addr, bus.inst_valid, bus.inst_addr, bus.inst_data});
    else n_pass++;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] ra;
    int          sel;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       ra = 32'h1FFC0 + $urandom_range(0, 63);
        1:       ra = 32'h20000 + $urandom_range(0, 255);
        default: ra = $urandom_range(0, 32'h3FF);
      endcase
      drive($urandom_range(0, 19) == 0, ra, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70);
      @(negedge clock);
      exp_v = model_expect();
      n_total++;
      if (obs_vec() !== exp_v) $display("FAIL random c%0d got %h want %h", c, obs_vec(), exp_v);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_fill();
    test_drain();
    test_top_bound();
    test_out_of_range();
    test_flush_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish within 1ms");
    $fatal(1);
  end
endmodule
